fir_output_decimator: RTL and testbench

//  Output stage of the FIR audio filter. Samples the wide accumulator once per PERIOD enabled cycles.

---
 rtl/fir_output_decimator.sv | 105 ++++++++++
 tb/tb_fir_output_decimator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fir_output_decimator.sv
// FIR audio output stage: decimates the accumulator by PERIOD, scales by >>> SHIFT and clamps to OUT_W.
// Optional round-half-up before the shift is enabled by defining FIR_OUT_ROUND_EN.
module fir_output_decimator #(
    parameter int ACC_W  = 25,
    parameter int OUT_W  = 20,
    parameter int SHIFT  = 5,
    parameter int PERIOD = 8,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    sync_clr,
    input  logic                    sat_clr,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    sat_flag,
    output logic [CNT_W-1:0]        phase
);

    // One guard bit above the accumulator so the rounding add cannot wrap.
    localparam int EXT_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(PERIOD - 1);
    localparam logic signed [EXT_W-1:0] MAX_EXT = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_EXT = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [EXT_W-1:0] RND_EXT = EXT_W'(1) << (SHIFT - 1);
`endif

    if (ACC_W < OUT_W + SHIFT) begin : g_bad_width
        $error("fir_output_decimator: ACC_W must be >= OUT_W + SHIFT");
    end
    if (SHIFT < 1 || PERIOD < 2 || (1 << CNT_W) < PERIOD) begin : g_bad_param
        $error("fir_output_decimator: need SHIFT>=1, PERIOD>=2, 2**CNT_W>=PERIOD");
    end

    function automatic logic signed [EXT_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] x;
        x = {a[ACC_W-1], a};
`ifdef FIR_OUT_ROUND_EN
        x = x + RND_EXT;
`endif
        return x >>> SHIFT;
    endfunction

    function automatic logic is_clipped(input logic signed [EXT_W-1:0] s);
        return (s > MAX_EXT) || (s < MIN_EXT);
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [EXT_W-1:0] s);
        if (s > MAX_EXT) return MAX_EXT[OUT_W-1:0];
        if (s < MIN_EXT) return MIN_EXT[OUT_W-1:0];
        return s[OUT_W-1:0];
    endfunction

    logic signed [EXT_W-1:0] scaled_p0;
    logic                    clip_p0;
    logic                    capture_p0;
    logic [CNT_W-1:0]        phase_p0;
    logic signed [OUT_W-1:0] dout_p1;
    logic                    vld_p1;
    logic                    sat_p1;

    // Stage p0: frame phase and capture decision; sync_clr overrides a capture.
    assign scaled_p0  = scale(acc_in);
    assign clip_p0    = is_clipped(scaled_p0);
    assign capture_p0 = en && !sync_clr && (phase_p0 == LAST_PHASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_p0 <= '0;
        end else if (sync_clr) begin
            phase_p0 <= '0;
        end else if (en) begin
            phase_p0 <= (phase_p0 == LAST_PHASE) ? '0 : phase_p0 + CNT_W'(1);
        end
    end

    // Stage p1: registered sample, one-cycle strobe and sticky clip flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            sat_p1  <= 1'b0;
        end else begin
            vld_p1 <= capture_p0;
            if (capture_p0) begin
                dout_p1 <= saturate(scaled_p0);
            end
            // A clamp in the same cycle as sat_clr must leave the flag set.
            if (capture_p0 && clip_p0) begin
                sat_p1 <= 1'b1;
            end else if (sat_clr) begin
                sat_p1 <= 1'b0;
            end
        end
    end

    assign dout       = dout_p1;
    assign dout_valid = vld_p1;
    assign sat_flag   = sat_p1;
    assign phase      = phase_p0;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator: a default instance plus an ACC_W=28 instance for clamping.
// Expected values follow FIR_OUT_ROUND_EN when the bench is built with it.
module tb_fir_output_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, sync_clr, sat_clr;
    logic signed [24:0] acc_a;
    logic signed [27:0] acc_b;
    logic signed [19:0] dout_a, dout_b;
    logic vld_a, vld_b, sat_a, sat_b;
    logic [3:0] phase_a, phase_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

`ifdef FIR_OUT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    fir_output_decimator dut (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .sat_clr(sat_clr),
        .acc_in(acc_a), .dout(dout_a), .dout_valid(vld_a), .sat_flag(sat_a), .phase(phase_a)
    );

    fir_output_decimator #(.ACC_W(28)) dut_w (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .sat_clr(sat_clr),
        .acc_in(acc_b), .dout(dout_b), .dout_valid(vld_b), .sat_flag(sat_b), .phase(phase_b)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the default instance strobes; n = edges taken, -1 on timeout.
    task automatic wait_valid(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (vld_a) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; sync_clr = 1'b0; sat_clr = 1'b0;
        acc_a = 25'sd416; acc_b = 28'sd0;
        tick(); tick();
        check("rst_phase", phase_a, 0);
        check("rst_dout", $signed(dout_a), 0);
        check("rst_valid", vld_a, 0);
        check("rst_sat", sat_a, 0);

        // Constant 416 -> 13, first strobe after 8 enabled edges, then every 8
        reset = 1'b0;
        wait_valid(n);
        check("first_valid_lat", n, 8);
        check("dout_416", $signed(dout_a), 13);
        check("wide_valid", vld_b, 1);
        tick();
        check("valid_one_cycle", vld_a, 0);
        check("dout_hold", $signed(dout_a), 13);
        wait_valid(n);
        check("period_next", n, 7);

        // Rounding behaviour at the half-LSB point
        acc_a = 25'sd496;
        wait_valid(n);
        check("period_496", n, 8);
        check("dout_496", $signed(dout_a), ROUND ? 16 : 15);
        acc_a = -25'sd496;
        wait_valid(n);
        check("dout_m496", $signed(dout_a), ROUND ? -15 : -16);
        check("sat_a_clear", sat_a, 0);

        // Wide instance clamps both ways; sat_clr clears, but a clamp wins over it
        acc_a = 25'sd416; acc_b = 28'sh7FFFFFF;
        wait_valid(n);
        check("wide_pos_dout", $signed(dout_b), 524287);
        check("wide_pos_sat", sat_b, 1);
        check("narrow_no_sat", sat_a, 0);
        acc_b = 28'sh8000000;
        wait_valid(n);
        check("wide_neg_dout", $signed(dout_b), -524288);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr", sat_b, 0);
        acc_b = 28'sd32;
        wait_valid(n);
        check("wide_small_dout", $signed(dout_b), 1);
        check("wide_small_nosat", sat_b, 0);
        acc_b = 28'sh7FFFFFF; sat_clr = 1'b1;
        wait_valid(n);
        check("sat_set_wins", sat_b, 1);
        sat_clr = 1'b0;

        // Full-scale default accumulator: only rounding can push it over
        acc_a = 25'sh0FFFFFF;
        wait_valid(n);
        check("max_dout", $signed(dout_a), 524287);
        check("max_sat", sat_a, ROUND ? 1 : 0);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        acc_a = 25'sh1000000;
        wait_valid(n);
        check("min_dout", $signed(dout_a), -524288);
        check("min_nosat", sat_a, 0);

        // en low for 3 cycles at phase 5 stretches the frame by exactly 3
        acc_a = 25'sd64;
        repeat (5) tick();
        check("phase5", phase_a, 5);
        en = 1'b0;
        repeat (3) tick();
        check("phase_hold", phase_a, 5);
        check("no_valid_en0", vld_a, 0);
        en = 1'b1;
        wait_valid(n);
        check("en_delay", n, 3);
        check("dout_64", $signed(dout_a), 2);

        // en low exactly at the capture phase suppresses the capture
        repeat (7) tick();
        check("phase7", phase_a, 7);
        en = 1'b0;
        tick();
        check("no_cap_en0", vld_a, 0);
        check("phase7_hold", phase_a, 7);
        en = 1'b1;
        wait_valid(n);
        check("cap_after_en", n, 1);

        // sync_clr at phase 7 beats the capture and restarts the frame
        acc_a = 25'sd96;
        repeat (7) tick();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        check("sync_no_valid", vld_a, 0);
        check("sync_phase", phase_a, 0);
        check("sync_dout_hold", $signed(dout_a), 2);
        wait_valid(n);
        check("sync_next", n, 8);
        check("dout_96", $signed(dout_a), 3);

        // Reset mid-frame clears everything and discards the partial frame
        repeat (4) tick();
        check("phase4", phase_a, 4);
        reset = 1'b1;
        tick();
        check("mid_rst_phase", phase_a, 0);
        check("mid_rst_dout", $signed(dout_a), 0);
        check("mid_rst_wide_dout", $signed(dout_b), 0);
        check("mid_rst_wide_sat", sat_b, 0);
        check("mid_rst_valid", vld_a, 0);
        reset = 1'b0;
        wait_valid(n);
        check("post_rst_lat", n, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
